// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
//   Shared types and constants for the load/store unit and its data memory
//   interface. Contents:
//     word_t                   - 32-bit data word
//     mem_en_t                 - memory access direction (read / write)
//     data_memory_interface_t  - request bundle driven towards data_memory
//     F3_*                     - RISC-V load/store width codes (funct3)
//     lsu_state_t              - load/store unit control states
//     funct3_fault()           - width/alignment legality check
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic {
      MEM_READ_EN  = 1'b0,
      MEM_WRITE_EN = 1'b1
   } mem_en_t;

   typedef struct packed {
      logic    mem_enable;
      mem_en_t mem_en;
      word_t   address;
      word_t   data_in;
   } data_memory_interface_t;

   // Quiescent memory request: nothing enabled, direction parked on read.
   localparam data_memory_interface_t MEM_IDLE = '{
      mem_enable : 1'b0,
      mem_en     : MEM_READ_EN,
      address    : 32'h0,
      data_in    : 32'h0
   };

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_WRITE,
      ST_RESP
   } lsu_state_t;

   // Wait counter holds 0 .. READ_LATENCY-1; READ_LATENCY is at most 4.
   localparam int unsigned LAT_CNT_W = 2;

   // Returns 1 when the width code is unusable for this access: reserved
   // codes, unsigned widths on a store, or a lane offset that would split the
   // access across a word boundary.
   function automatic logic funct3_fault(input logic [2:0] funct3,
                                         input logic       write,
                                         input logic [1:0] lane);
      logic fault;
      case (funct3)
         F3_B:    fault = 1'b0;
         F3_H:    fault = lane[0];
         F3_W:    fault = |lane;
         F3_BU:   fault = write;
         F3_HU:   fault = write | lane[0];
         default: fault = 1'b1;
      endcase
      return fault;
   endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// -----------------------------------------------------------------------------
// lsu_align
//   Purely combinational lane logic for the load/store unit.
//   Ports:
//     i_funct3     - width code of the access
//     i_lane       - byte offset within the word (address[1:0])
//     i_rdata      - word read from memory
//     i_wdata      - right-aligned store data
//     o_load_data  - selected lane, sign- or zero-extended to 32 bits
//     o_store_word - i_rdata with the addressed lane replaced by store data
//                    (the whole of i_wdata for a word access)
// -----------------------------------------------------------------------------
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0] i_funct3,
   input  logic [1:0] i_lane,
   input  word_t      i_rdata,
   input  word_t      i_wdata,
   output word_t      o_load_data,
   output word_t      o_store_word
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // NOTE: every signal driven from always_comb is given a value on entry so
   // that no path through the case statements leaves it holding state; a
   // missing default here would infer a latch.
   always_comb begin
      w_byte       = 8'h00;
      w_half       = 16'h0000;
      o_load_data  = '0;
      o_store_word = i_rdata;

      case (i_lane)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

      case (i_funct3)
         F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_load_data = {24'h000000, w_byte};
         F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
         F3_HU:   o_load_data = {16'h0000, w_half};
         F3_W:    o_load_data = i_rdata;
         default: o_load_data = '0;
      endcase

      // Only B/H stores reach the merge; BU/HU stores are rejected up front.
      case (i_funct3)
         F3_B:    o_store_word[{i_lane, 3'b000} +: 8]     = i_wdata[7:0];
         F3_H:    o_store_word[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
         F3_W:    o_store_word = i_wdata;
         default: o_store_word = i_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Initiator side of the data memory interface. Takes one load or store at a
//   time from the execute stage, performs it against a word-only memory
//   (sub-word stores become read-modify-write) and returns a single-cycle
//   completion pulse. Illegal, misaligned or out-of-range requests complete
//   with resp_fault and never touch memory.
//   Parameters:
//     READ_LATENCY    - cycles from read request to valid mem_rdata (1..4)
//     ADDR_RANGE_BITS - byte-address bits backed by memory
//   Ports:
//     clock, reset_n   - rising-edge clock, asynchronous active-low reset
//     req_valid/ready  - request handshake (ready only while idle)
//     req_write        - 1 = store, 0 = load
//     req_funct3       - RISC-V width code
//     req_address      - byte address
//     req_wdata        - right-aligned store data
//     resp_valid       - one-cycle completion pulse
//     resp_rdata       - extended load data, 0 for stores and faults
//     resp_fault       - request rejected (valid with resp_valid)
//     mem_sig          - request bundle to data_memory
//     mem_rdata        - read data from data_memory
// -----------------------------------------------------------------------------
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned READ_LATENCY    = 1,
   parameter int unsigned ADDR_RANGE_BITS = 10
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [2:0]             req_funct3,
   input  logic [31:0]            req_address,
   input  logic [31:0]            req_wdata,
   output logic                   resp_valid,
   output logic [31:0]            resp_rdata,
   output logic                   resp_fault,
   output data_memory_interface_t mem_sig,
   input  word_t                  mem_rdata
);

   // Captured request
   logic                   r_write;
   logic [2:0]             r_funct3;
   logic [31:0]            r_addr;
   word_t                  r_wdata;

   // Control and registered outputs
   lsu_state_t             r_state;
   logic [LAT_CNT_W-1:0]   r_wait_cnt;
   logic                   r_req_ready;
   logic                   r_resp_valid;
   word_t                  r_resp_rdata;
   logic                   r_resp_fault;
   data_memory_interface_t r_mem_sig;

   logic                   w_fault;
   logic                   w_wait_done;
   word_t                  w_load_data;
   word_t                  w_store_word;

   // Legality is judged on the live request so a bad request never leaves IDLE
   // towards memory.
   assign w_fault = funct3_fault(req_funct3, req_write, req_address[1:0])
                    | (|(req_address >> ADDR_RANGE_BITS));

   assign w_wait_done = (r_wait_cnt == LAT_CNT_W'(READ_LATENCY - 1));

   lsu_align u_align (
      .i_funct3     (r_funct3),
      .i_lane       (r_addr[1:0]),
      .i_rdata      (mem_rdata),
      .i_wdata      (r_wdata),
      .o_load_data  (w_load_data),
      .o_store_word (w_store_word)
   );

   // All outputs are registered: each branch sets the values the outputs must
   // carry in the state being entered. The registered mem_sig.data_in doubles
   // as the write buffer for the merged word.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side sees pre-edge values and later per-branch assignments
   // cleanly override the per-cycle defaults set at the top.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_wait_cnt   <= '0;
         r_req_ready  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_fault <= 1'b0;
         r_mem_sig    <= MEM_IDLE;
         r_write      <= 1'b0;
         r_funct3     <= F3_B;
         r_addr       <= '0;
         r_wdata      <= '0;
      end else begin
         r_resp_valid         <= 1'b0;
         r_resp_rdata         <= '0;
         r_resp_fault         <= 1'b0;
         r_mem_sig.mem_enable <= 1'b0;
         r_mem_sig.mem_en     <= MEM_READ_EN;
         r_mem_sig.data_in    <= '0;

         case (r_state)
            ST_IDLE: begin
               if (req_valid && r_req_ready) begin
                  r_write     <= req_write;
                  r_funct3    <= req_funct3;
                  r_addr      <= req_address;
                  r_wdata     <= req_wdata;
                  r_req_ready <= 1'b0;
                  if (w_fault) begin
                     r_state      <= ST_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_fault <= 1'b1;
                  end else if (req_write && (req_funct3 == F3_W)) begin
                     // Full-word store needs no read of the old contents.
                     r_state              <= ST_WRITE;
                     r_mem_sig.mem_enable <= 1'b1;
                     r_mem_sig.mem_en     <= MEM_WRITE_EN;
                     r_mem_sig.address    <= {req_address[31:2], 2'b00};
                     r_mem_sig.data_in    <= req_wdata;
                  end else begin
                     r_state              <= ST_READ;
                     r_mem_sig.mem_enable <= 1'b1;
                     r_mem_sig.address    <= {req_address[31:2], 2'b00};
                  end
               end else begin
                  // Ready rises one cycle after reset release and after RESP.
                  r_req_ready <= 1'b1;
               end
            end

            ST_READ: begin
               r_state    <= ST_WAIT;
               r_wait_cnt <= '0;
            end

            ST_WAIT: begin
               if (w_wait_done) begin
                  if (r_write) begin
                     r_state              <= ST_WRITE;
                     r_mem_sig.mem_enable <= 1'b1;
                     r_mem_sig.mem_en     <= MEM_WRITE_EN;
                     r_mem_sig.address    <= {r_addr[31:2], 2'b00};
                     r_mem_sig.data_in    <= w_store_word;
                  end else begin
                     r_state      <= ST_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_rdata <= w_load_data;
                  end
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end

            ST_WRITE: begin
               r_state      <= ST_RESP;
               r_resp_valid <= 1'b1;
            end

            ST_RESP: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b1;
            end

            default: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_fault = r_resp_fault;
   assign mem_sig    = r_mem_sig;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit. Two instances share the request
//   fields: u_l1 (READ_LATENCY=1) and u_l3 (READ_LATENCY=3), each with its
//   own word-only memory model. Cycle numbers count from the accept edge.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req_valid1;
   logic        req_valid3;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_address;
   logic [31:0] req_wdata;

   logic                   rdy1, rv1, flt1;
   logic [31:0]            rd1;
   data_memory_interface_t ms1;
   word_t                  mrd1;

   logic                   rdy3, rv3, flt3;
   logic [31:0]            rd3;
   data_memory_interface_t ms3;
   word_t                  mrd3;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   load_store_unit #(.READ_LATENCY(1), .ADDR_RANGE_BITS(10)) u_l1 (
      .clock       (clock),
      .reset_n     (reset_n),
      .req_valid   (req_valid1),
      .req_ready   (rdy1),
      .req_write   (req_write),
      .req_funct3  (req_funct3),
      .req_address (req_address),
      .req_wdata   (req_wdata),
      .resp_valid  (rv1),
      .resp_rdata  (rd1),
      .resp_fault  (flt1),
      .mem_sig     (ms1),
      .mem_rdata   (mrd1)
   );

   load_store_unit #(.READ_LATENCY(3), .ADDR_RANGE_BITS(10)) u_l3 (
      .clock       (clock),
      .reset_n     (reset_n),
      .req_valid   (req_valid3),
      .req_ready   (rdy3),
      .req_write   (req_write),
      .req_funct3  (req_funct3),
      .req_address (req_address),
      .req_wdata   (req_wdata),
      .resp_valid  (rv3),
      .resp_rdata  (rd3),
      .resp_fault  (flt3),
      .mem_sig     (ms3),
      .mem_rdata   (mrd3)
   );

   // ---------------- memory models (word-only, preloaded on first edge) -----
   word_t mem1 [0:255];
   word_t pipe1;
   int    wr_cnt1 = 0;
   int    en_cnt1 = 0;
   bit    init1   = 1'b0;

   always @(posedge clock) begin
      if (!init1) begin
         mem1[8'h10] = 32'h8899AABB;
         mem1[8'h11] = 32'h11223344;
         init1       = 1'b1;
      end
      pipe1 <= mem1[ms1.address[9:2]];
      if (ms1.mem_enable) en_cnt1 <= en_cnt1 + 1;
      if (ms1.mem_enable && ms1.mem_en == MEM_WRITE_EN) begin
         mem1[ms1.address[9:2]] = ms1.data_in;
         wr_cnt1 <= wr_cnt1 + 1;
      end
   end
   assign mrd1 = pipe1;

   word_t mem3 [0:255];
   word_t pipe3a, pipe3b, pipe3c;
   int    wr_cnt3 = 0;
   int    en_cnt3 = 0;
   bit    init3   = 1'b0;

   always @(posedge clock) begin
      if (!init3) begin
         mem3[8'h10] = 32'h8899AABB;
         mem3[8'h11] = 32'h11223344;
         init3       = 1'b1;
      end
      pipe3a <= mem3[ms3.address[9:2]];
      pipe3b <= pipe3a;
      pipe3c <= pipe3b;
      if (ms3.mem_enable) en_cnt3 <= en_cnt3 + 1;
      if (ms3.mem_enable && ms3.mem_en == MEM_WRITE_EN) begin
         mem3[ms3.address[9:2]] = ms3.data_in;
         wr_cnt3 <= wr_cnt3 + 1;
      end
   end
   assign mrd3 = pipe3c;

   // ---------------- helpers ------------------------------------------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic set_valid(input bit sel, input logic v);
      if (sel) req_valid3 = v;
      else     req_valid1 = v;
   endtask

   task automatic check_l1_reset_outputs(input string tag);
      check({tag, " req_ready"},  32'(rdy1), 32'd0);
      check({tag, " resp_valid"}, 32'(rv1), 32'd0);
      check({tag, " resp_rdata"}, rd1, 32'h0);
      check({tag, " resp_fault"}, 32'(flt1), 32'd0);
      check({tag, " mem_enable"}, 32'(ms1.mem_enable), 32'd0);
      check({tag, " mem_en"},     32'(ms1.mem_en), 32'(MEM_READ_EN));
      check({tag, " address"},    ms1.address, 32'h0);
      check({tag, " data_in"},    ms1.data_in, 32'h0);
   endtask

   // One full request: wait for ready, accept, scramble the inputs, then time
   // the completion pulse and the memory traffic it caused.
   task automatic run_req(input bit sel, input logic wr, input logic [2:0] f3,
                          input word_t addr, input word_t wdata,
                          input int exp_cyc, input word_t exp_rdata,
                          input logic exp_fault, input int exp_wr,
                          input int exp_en, input string tag);
      int    got_cyc;
      word_t got_rdata;
      logic  got_fault;
      int    wr0;
      int    en0;
      int    wait_n;
      bit    ready_low;

      @(negedge clock);
      req_write   = wr;
      req_funct3  = f3;
      req_address = addr;
      req_wdata   = wdata;
      set_valid(sel, 1'b1);
      wait_n = 0;
      while (!(sel ? rdy3 : rdy1) && wait_n < 20) begin
         @(negedge clock);
         wait_n++;
      end
      check({tag, " ready"}, 32'(sel ? rdy3 : rdy1), 32'd1);
      wr0 = sel ? wr_cnt3 : wr_cnt1;
      en0 = sel ? en_cnt3 : en_cnt1;

      @(posedge clock);
      got_cyc   = -1;
      got_rdata = '0;
      got_fault = 1'b0;
      ready_low = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clock);
         if (c == 1) begin
            set_valid(sel, 1'b0);
            req_address = ~addr;
            req_wdata   = ~wdata;
            req_funct3  = 3'b111;
            req_write   = ~wr;
         end
         if (sel ? rdy3 : rdy1) ready_low = 1'b0;
         if (sel ? rv3 : rv1) begin
            got_cyc   = c;
            got_rdata = sel ? rd3 : rd1;
            got_fault = sel ? flt3 : flt1;
            break;
         end
      end
      check({tag, " cycles"},    32'(got_cyc), 32'(exp_cyc));
      check({tag, " rdata"},     got_rdata, exp_rdata);
      check({tag, " fault"},     32'(got_fault), 32'(exp_fault));
      check({tag, " writes"},    32'((sel ? wr_cnt3 : wr_cnt1) - wr0), 32'(exp_wr));
      check({tag, " enables"},   32'((sel ? en_cnt3 : en_cnt1) - en0), 32'(exp_en));
      check({tag, " ready_low"}, 32'(ready_low), 32'd1);
   endtask

   // ---------------- directed sequence --------------------------------------
   initial begin
      int    wait_n;
      int    got_cyc;
      int    wr0;
      word_t got_rdata;
      bit    ready_low;

      reset_n     = 1'b0;
      req_valid1  = 1'b0;
      req_valid3  = 1'b0;
      req_write   = 1'b0;
      req_funct3  = F3_B;
      req_address = 32'h0;
      req_wdata   = 32'h0;

      // Reset values, then ready one cycle after release.
      @(negedge clock);
      @(negedge clock);
      check_l1_reset_outputs("por");
      check("por l3 req_ready", 32'(rdy3), 32'd0);
      reset_n = 1'b1;
      #1;
      check("release ready_same_cycle", 32'(rdy1), 32'd0);
      @(negedge clock);
      check("release ready_next_cycle", 32'(rdy1), 32'd1);

      // Loads with READ_LATENCY=1: word 0x40 = 0x8899AABB.
      run_req(1'b0, 1'b0, F3_B,  32'h41, 32'h0, 3, 32'hFFFFFFAA, 1'b0, 0, 1, "l1 LB 0x41");
      run_req(1'b0, 1'b0, F3_BU, 32'h41, 32'h0, 3, 32'h000000AA, 1'b0, 0, 1, "l1 LBU 0x41");
      run_req(1'b0, 1'b0, F3_H,  32'h42, 32'h0, 3, 32'hFFFF8899, 1'b0, 0, 1, "l1 LH 0x42");
      run_req(1'b0, 1'b0, F3_HU, 32'h40, 32'h0, 3, 32'h0000AABB, 1'b0, 0, 1, "l1 LHU 0x40");

      // Sub-word store: read-modify-write, byte lane 2 only.
      run_req(1'b0, 1'b1, F3_B, 32'h42, 32'h12345611, 4, 32'h0, 1'b0, 1, 2, "l1 SB 0x42");
      check("l1 SB mem word", mem1[8'h10], 32'h8811AABB);

      // Word store goes straight to WRITE; restores the original word.
      run_req(1'b0, 1'b1, F3_W, 32'h40, 32'h8899AABB, 2, 32'h0, 1'b0, 1, 1, "l1 SW 0x40");
      check("l1 SW mem word", mem1[8'h10], 32'h8899AABB);

      // Faults: one cycle, no memory activity, zero data.
      run_req(1'b0, 1'b1, F3_W,   32'h46,  32'hDEADBEEF, 1, 32'h0, 1'b1, 0, 0, "fault SW 0x46");
      run_req(1'b0, 1'b0, F3_W,   32'h400, 32'h0,        1, 32'h0, 1'b1, 0, 0, "fault LW 0x400");
      run_req(1'b0, 1'b0, 3'b011, 32'h40,  32'h0,        1, 32'h0, 1'b1, 0, 0, "fault f3 011");
      run_req(1'b0, 1'b1, F3_BU,  32'h40,  32'h55,       1, 32'h0, 1'b1, 0, 0, "fault store BU");
      run_req(1'b0, 1'b0, F3_H,   32'h43,  32'h0,        1, 32'h0, 1'b1, 0, 0, "fault LH 0x43");
      check("fault mem word", mem1[8'h10], 32'h8899AABB);

      // SH 0x40 abandoned by reset during WAIT.
      @(negedge clock);
      req_write   = 1'b1;
      req_funct3  = F3_H;
      req_address = 32'h40;
      req_wdata   = 32'h0000BEEF;
      req_valid1  = 1'b1;
      wait_n = 0;
      while (!rdy1 && wait_n < 20) begin
         @(negedge clock);
         wait_n++;
      end
      check("rst SH ready", 32'(rdy1), 32'd1);
      wr0 = wr_cnt1;
      @(posedge clock);
      @(negedge clock);                 // cycle 1: READ
      req_valid1 = 1'b0;
      check("rst SH read issued", 32'(ms1.mem_enable), 32'd1);
      @(negedge clock);                 // cycle 2: WAIT
      reset_n = 1'b0;
      #1;
      check_l1_reset_outputs("rst mid");
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      check("rst release ready_same_cycle", 32'(rdy1), 32'd0);
      @(negedge clock);
      check("rst release ready_next_cycle", 32'(rdy1), 32'd1);
      check("rst SH no write", 32'(wr_cnt1 - wr0), 32'd0);
      check("rst SH mem word", mem1[8'h10], 32'h8899AABB);
      run_req(1'b0, 1'b0, F3_W, 32'h40, 32'h0, 3, 32'h8899AABB, 1'b0, 0, 1, "post rst LW 0x40");

      // Back-to-back LW 0x40 / 0x44 with req_valid held high.
      @(negedge clock);
      req_write   = 1'b0;
      req_funct3  = F3_W;
      req_address = 32'h40;
      req_valid1  = 1'b1;
      wait_n = 0;
      while (!rdy1 && wait_n < 20) begin
         @(negedge clock);
         wait_n++;
      end
      check("b2b first ready", 32'(rdy1), 32'd1);
      @(posedge clock);
      got_cyc   = -1;
      got_rdata = '0;
      ready_low = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clock);
         if (c == 1) req_address = 32'h44;
         if (rdy1) ready_low = 1'b0;
         if (rv1) begin
            got_cyc   = c;
            got_rdata = rd1;
            break;
         end
      end
      check("b2b first cycles", 32'(got_cyc), 32'd3);
      check("b2b first rdata", got_rdata, 32'h8899AABB);
      check("b2b first ready_low", 32'(ready_low), 32'd1);
      @(negedge clock);
      check("b2b second accept ready", 32'(rdy1), 32'd1);
      @(posedge clock);
      got_cyc   = -1;
      got_rdata = '0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clock);
         if (c == 1) req_valid1 = 1'b0;
         if (rv1) begin
            got_cyc   = c;
            got_rdata = rd1;
            break;
         end
      end
      check("b2b second cycles", 32'(got_cyc), 32'd3);
      check("b2b second rdata", got_rdata, 32'h11223344);

      // Same loads with READ_LATENCY=3.
      run_req(1'b1, 1'b0, F3_B,  32'h41, 32'h0, 5, 32'hFFFFFFAA, 1'b0, 0, 1, "l3 LB 0x41");
      run_req(1'b1, 1'b0, F3_BU, 32'h41, 32'h0, 5, 32'h000000AA, 1'b0, 0, 1, "l3 LBU 0x41");
      run_req(1'b1, 1'b0, F3_H,  32'h42, 32'h0, 5, 32'hFFFF8899, 1'b0, 0, 1, "l3 LH 0x42");
      run_req(1'b1, 1'b0, F3_HU, 32'h42, 32'h0, 5, 32'h00008899, 1'b0, 0, 1, "l3 LHU 0x42");
      run_req(1'b1, 1'b1, F3_H,  32'h40, 32'h0000BEEF, 6, 32'h0, 1'b0, 1, 2, "l3 SH 0x40");
      check("l3 SH mem word", mem3[8'h10], 32'h8899BEEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data memory interface; sits between the execute stage and data_memory.
- Accepts one load/store request at a time and drives data_memory_interface_t.
- Loads: extracts and sign/zero-extends bytes and halfwords.
- Sub-word stores: read-modify-write of the containing word, because data_memory writes whole words only.
- Flags misaligned, out-of-range and illegal-funct3 requests as faults without touching memory.

Parameters:
- READ_LATENCY, 1, cycles from a read-request cycle to the cycle mem_rdata is valid; legal range 1-4.
- ADDR_RANGE_BITS, 10, byte-address bits backed by memory; any set bit in address[31:ADDR_RANGE_BITS] is a fault.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  unit can accept; high only in IDLE with reset_n high.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_address  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse; core always accepts.
- resp_rdata  output  32  extended load data; 0 for stores and faults.
- resp_fault  output  1  valid with resp_valid; request was rejected.
- mem_sig  output  data_memory_interface_t  fields mem_enable, mem_en, address, data_in.
- mem_rdata  input  word  memory read data, READ_LATENCY cycles after the read request.

Behaviour:
- Reset (async, reset_n low): state IDLE; req_ready=0; resp_valid=0; resp_rdata=0; resp_fault=0; mem_sig.mem_enable=0, mem_en=MEM_READ_EN, address=0, data_in=0. Reset mid-operation abandons the request; no write is issued, and memory keeps its pre-request contents.
- Accept: req_valid && req_ready at a rising edge. The edge captures write, funct3, address and wdata into request registers.
- States: IDLE, READ, WAIT, WRITE, RESP.
- Fault check at accept (combinational on request inputs), giving IDLE->RESP with resp_fault=1. Fault causes:
  - funct3 in {011, 110, 111};
  - a store with funct3 BU/HU;
  - H/HU with address[0]=1;
  - W with address[1:0]!=0;
  - address out of range.
- Non-fault transitions:
  - word store: IDLE->WRITE;
  - load or sub-word store: IDLE->READ.
- READ (1 cycle): mem_enable=1, mem_en=MEM_READ_EN, address={addr[31:2],2'b00}. Next state is WAIT.
- WAIT: a counter runs for READ_LATENCY cycles. In the last WAIT cycle mem_rdata is captured:
  - load: extract and extend into the response register, then go to RESP;
  - store: merge into a write buffer, then go to WRITE.
- Extraction:
  - B/BU use lane addr[1:0]: bits [8k+7:8k];
  - H/HU use lane addr[1]: bits [16k+15:16k];
  - B and H sign-extend; BU and HU zero-extend.
- Merge: replace only the addressed lane with wdata[7:0] or wdata[15:0]; all other bytes are preserved.
- WRITE (1 cycle): mem_enable=1, mem_en=MEM_WRITE_EN, word address, data_in = wdata (word store) or the merged buffer. Next state is RESP.
- RESP (1 cycle): resp_valid=1, then IDLE. req_ready is 0 here; the next request can be accepted in IDLE at the earliest.
- Outside READ and WRITE: mem_enable=0, mem_en=MEM_READ_EN, data_in=0.
- Latency in cycles after the accept cycle (L = READ_LATENCY):
  - fault: 1;
  - word store: 2;
  - load: L+2;
  - sub-word store: L+3.
- Request inputs are ignored outside the accept edge; they may change freely.

Decomposition:
- params.sv additions:
  - mem_en_t gains MEM_READ_EN alongside MEM_WRITE_EN;
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - lsu_state_t enum.
- Sub-module lsu_align (combinational): inputs are funct3, addr[1:0], the memory word and the store data; outputs are the extended load value and the merged store word. It can be unit-tested standalone.

Test Plan:
- Word at 0x40 = 0x8899AABB, L=1.
  - LB 0x41 -> resp_valid in cycle 3, resp_rdata=0xFFFFFFAA, fault=0.
  - LBU 0x41 -> resp_rdata=0x000000AA.
  - LH 0x42 -> 0xFFFF8899.
- SB 0x42 with wdata 0x12345611 -> one read then one write of 0x8811AABB to word 0x40; resp_valid in cycle 4; exactly one mem write observed.
- SW 0x46 (misaligned), LW 0x400 (out of range), funct3=011 -> resp_fault=1 in cycle 1, mem_enable never asserted, resp_rdata=0.
- SH 0x40 with 0xBEEF, reset_n pulsed low during WAIT -> no MEM_WRITE_EN cycle, word stays 0x8899AABB, outputs at reset values, req_ready=1 one cycle after release.
- req_valid held high with two back-to-back LW 0x40 and 0x44 (L=1):
  - second accept occurs the cycle after the first resp_valid;
  - req_ready is 0 throughout the first request.
- Repeat the load tests with READ_LATENCY=3 -> LB completes in cycle 5 with identical data.
